id_issue: RTL and testbench

Instruction decode and issue stage for the 8-bit MIPS pipeline. Accepts 32-bit instructions from fetch, reads the integrated register file, and generates main control. It sign-extends or truncates the immediate and detects load-use hazards. It presents a registered operand/control bundle to the execute stage: readd1, readd2, ALUop, ALUSrc, SignExtendOut and funct. It also owns the register-file write port fed from writeback.

---
 rtl/id_issue.sv | 201 ++++++++++++++++++++
 tb/tb_id_issue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_issue.sv
// Decode/issue stage: register file, main control, immediate and load-use stall.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data into captured operands.
module id_issue #(
  parameter int DATA_WIDTH = 8,
  parameter int IMM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           in_instr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] readd1,
  output logic [DATA_WIDTH-1:0] readd2,
  output logic [IMM_WIDTH-1:0]  SignExtendOut,
  output logic [1:0]            ALUop,
  output logic                  ALUSrc,
  output logic [5:0]            funct,
  output logic [4:0]            dest,
  output logic                  RegWrite,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  Branch,
  output logic                  illegal
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef enum logic {S_RUN, S_STALL} state_t;

  function automatic logic [IMM_WIDTH-1:0] f_imm(input logic [31:0] instr);
    logic [31:0] sx;
    sx = {{16{instr[15]}}, instr[15:0]};
    if (IMM_WIDTH <= 16) return instr[IMM_WIDTH-1:0];
    else                 return sx[IMM_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] r_rf [32];
  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_vld_p1;
  logic [DATA_WIDTH-1:0] r_rd1_p1, r_rd2_p1;
  logic [IMM_WIDTH-1:0]  r_imm_p1;
  logic [1:0]            r_aluop_p1;
  logic                  r_alusrc_p1, r_regwr_p1, r_memrd_p1, r_memwr_p1, r_br_p1;
  logic [5:0]            r_funct_p1;
  logic [4:0]            r_dest_p1;
  logic                  r_illegal;

  logic [5:0]            w_op;
  logic [4:0]            w_rs, w_rt, w_rd;
  logic [1:0]            w_aluop;
  logic                  w_alusrc, w_regwr, w_memrd, w_memwr, w_br;
  logic [4:0]            w_dest;
  logic                  w_uses_rt, w_illegal_op;
  logic [DATA_WIDTH-1:0] w_rd1, w_rd2;
  logic                  w_hazard, w_adv, w_load_dec, w_load_nop;
  logic                  w_unused;

  assign w_op     = in_instr[31:26];
  assign w_rs     = in_instr[25:21];
  assign w_rt     = in_instr[20:16];
  assign w_rd     = in_instr[15:11];
  assign w_unused = ^in_instr[15:6];

  always_comb begin
    w_aluop      = 2'b00;
    w_alusrc     = 1'b0;
    w_regwr      = 1'b0;
    w_memrd      = 1'b0;
    w_memwr      = 1'b0;
    w_br         = 1'b0;
    w_dest       = 5'd0;
    w_uses_rt    = 1'b0;
    w_illegal_op = 1'b0;
    case (w_op)
      OP_R:    begin w_aluop = 2'b10; w_regwr = 1'b1; w_dest = w_rd; w_uses_rt = 1'b1; end
      OP_LW:   begin w_alusrc = 1'b1; w_memrd = 1'b1; w_regwr = 1'b1; w_dest = w_rt; end
      OP_SW:   begin w_alusrc = 1'b1; w_memwr = 1'b1; w_uses_rt = 1'b1; end
      OP_BEQ:  begin w_aluop = 2'b01; w_br = 1'b1; w_uses_rt = 1'b1; end
      OP_ADDI: begin w_alusrc = 1'b1; w_regwr = 1'b1; w_dest = w_rt; end
      default: w_illegal_op = 1'b1;
    endcase
  end

  // Operand read; r0 is never written so it always reads zero.
  always_comb begin
    w_rd1 = r_rf[w_rs];
    w_rd2 = r_rf[w_rt];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == w_rs)) w_rd1 = wb_data;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == w_rt)) w_rd2 = wb_data;
`endif
  end

  // A NOP already sitting in the output (STALL) cannot raise a load-use hazard.
  assign w_hazard = (r_state == S_RUN) && in_valid && r_vld_p1 && r_memrd_p1 &&
                    (r_dest_p1 != 5'd0) &&
                    ((w_rs == r_dest_p1) || (w_uses_rt && (w_rt == r_dest_p1)));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush)      w_state_nxt = S_RUN;
    else if (w_adv) w_state_nxt = w_hazard ? S_STALL : S_RUN;
  end

  always_comb begin
    w_adv      = !r_vld_p1 || out_ready;
    in_ready   = !flush && w_adv && !w_hazard;
    w_load_dec = in_ready && in_valid;
    w_load_nop = !flush && w_adv && w_hazard;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Stage p1: registered bundle toward execute.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1    <= 1'b0;
      r_rd1_p1    <= '0;
      r_rd2_p1    <= '0;
      r_imm_p1    <= '0;
      r_aluop_p1  <= 2'b00;
      r_alusrc_p1 <= 1'b0;
      r_funct_p1  <= 6'd0;
      r_dest_p1   <= 5'd0;
      r_regwr_p1  <= 1'b0;
      r_memrd_p1  <= 1'b0;
      r_memwr_p1  <= 1'b0;
      r_br_p1     <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_load_dec) begin
      r_vld_p1    <= 1'b1;
      r_rd1_p1    <= w_illegal_op ? '0 : w_rd1;
      r_rd2_p1    <= w_illegal_op ? '0 : w_rd2;
      r_imm_p1    <= w_illegal_op ? '0 : f_imm(in_instr);
      r_funct_p1  <= w_illegal_op ? 6'd0 : in_instr[5:0];
      r_aluop_p1  <= w_aluop;
      r_alusrc_p1 <= w_alusrc;
      r_dest_p1   <= w_dest;
      r_regwr_p1  <= w_regwr;
      r_memrd_p1  <= w_memrd;
      r_memwr_p1  <= w_memwr;
      r_br_p1     <= w_br;
      r_illegal   <= r_illegal | w_illegal_op;
    end else if (w_load_nop) begin
      r_vld_p1    <= 1'b1;
      r_rd1_p1    <= '0;
      r_rd2_p1    <= '0;
      r_imm_p1    <= '0;
      r_funct_p1  <= 6'd0;
      r_aluop_p1  <= 2'b00;
      r_alusrc_p1 <= 1'b0;
      r_dest_p1   <= 5'd0;
      r_regwr_p1  <= 1'b0;
      r_memrd_p1  <= 1'b0;
      r_memwr_p1  <= 1'b0;
      r_br_p1     <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid     = r_vld_p1;
  assign readd1        = r_rd1_p1;
  assign readd2        = r_rd2_p1;
  assign SignExtendOut = r_imm_p1;
  assign ALUop         = r_aluop_p1;
  assign ALUSrc        = r_alusrc_p1;
  assign funct         = r_funct_p1;
  assign dest          = r_dest_p1;
  assign RegWrite      = r_regwr_p1;
  assign MemRead       = r_memrd_p1;
  assign MemWrite      = r_memwr_p1;
  assign Branch        = r_br_p1;
  assign illegal       = r_illegal;

endmodule

// File: tb/tb_id_issue.sv
// Scoreboard bench for id_issue: driver queues expected bundles, monitor checks them on consume.
module tb_id_issue;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [4:0]  wb_addr, dest;
  logic [7:0]  wb_data, readd1, readd2, SignExtendOut;
  logic [1:0]  ALUop;
  logic        ALUSrc, RegWrite, MemRead, MemWrite, Branch, illegal;
  logic [5:0]  funct;

  typedef struct packed {
    logic [7:0] rd1, rd2, imm;
    logic [1:0] aluop;
    logic       alusrc;
    logic [5:0] funct;
    logic [4:0] dest;
    logic       rw, mr, mw, br;
    logic       nop;
  } bundle_t;

  bundle_t sb[$];
  string   nm_q[$];
  int      n_vec = 0;
  int      n_miss = 0;
  int      w;

  localparam bundle_t NOP_B = '{default: '0, nop: 1'b1};

  id_issue #(.DATA_WIDTH(8), .IMM_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .readd1(readd1), .readd2(readd2),
    .SignExtendOut(SignExtendOut), .ALUop(ALUop), .ALUSrc(ALUSrc), .funct(funct), .dest(dest),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .illegal(illegal));

  always #5 clk = ~clk;

  function automatic bundle_t mk(input logic [7:0] rd1, rd2, imm, input logic [1:0] aluop,
                                 input logic alusrc, input logic [5:0] fn, input logic [4:0] d,
                                 input logic rw, mr, mw, br);
    return '{rd1: rd1, rd2: rd2, imm: imm, aluop: aluop, alusrc: alusrc, funct: fn, dest: d,
             rw: rw, mr: mr, mw: mw, br: br, nop: 1'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // NOP bundles only define control, dest and operands; immediate/funct are don't-care.
  task automatic cmp_bundle(input string name, input bundle_t exp);
    bundle_t a;
    a = '{rd1: readd1, rd2: readd2, imm: SignExtendOut, aluop: ALUop, alusrc: ALUSrc,
          funct: funct, dest: dest, rw: RegWrite, mr: MemRead, mw: MemWrite, br: Branch, nop: 1'b0};
    if (exp.nop) begin
      a.imm = '0; a.funct = '0; a.nop = 1'b1;
    end
    chk(name, 64'(a), 64'(exp));
  endtask

  initial begin : monitor
    bundle_t e;
    string   n;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_bundle: got readd1=%h dest=%0d, expected none", readd1, dest);
        end else begin
          e = sb.pop_front();
          n = nm_q.pop_front();
          cmp_bundle(n, e);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input bundle_t exp, input string nm,
                       input bit stall_nop, output int waits);
    bit done;
    in_instr = ins; in_valid = 1'b1; waits = 0; done = 1'b0;
    if (stall_nop) begin
      sb.push_back(NOP_B); nm_q.push_back({nm, "_nop"});
    end
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp); nm_q.push_back(nm); done = 1'b1;
      end else begin
        waits++;
        if (waits > 20) begin
          n_vec++; n_miss++;
          $display("FAIL %s_timeout: got in_ready=0, expected accept within 20 cycles", nm);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [7:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_illegal", 64'(illegal), 64'd0);
    cmp_bundle("rst_bundle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;

    wb_write(5'd1, 8'h05);
    wb_write(5'd2, 8'h03);

    issue(32'h00221820, mk(8'h05, 8'h03, 8'h20, 2'b10, 0, 6'h20, 5'd3, 1, 0, 0, 0), "add_r3", 0, w);
    chk("add_r3_wait", 64'(w), 64'd0);
    issue(32'h2024FFFE, mk(8'h05, 8'h00, 8'hFE, 2'b00, 1, 6'h3E, 5'd4, 1, 0, 0, 0), "addi_r4", 0, w);
    issue(32'h8C250004, mk(8'h05, 8'h00, 8'h04, 2'b00, 1, 6'h04, 5'd5, 1, 1, 0, 0), "lw_r5", 0, w);
    issue(32'h00A23020, mk(8'h00, 8'h03, 8'h20, 2'b10, 0, 6'h20, 5'd6, 1, 0, 0, 0), "add_dep", 1, w);
    chk("loaduse_stall_cycles", 64'(w), 64'd1);
    idle(2);

    // Back-pressure: output held, upstream blocked for three cycles.
    out_ready = 1'b0;
    issue(32'hAC220008, mk(8'h05, 8'h03, 8'h08, 2'b00, 1, 6'h08, 5'd0, 0, 0, 1, 0), "sw", 0, w);
    in_instr = 32'h10220010; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      cmp_bundle("hold_bundle", mk(8'h05, 8'h03, 8'h08, 2'b00, 1, 6'h08, 5'd0, 0, 0, 1, 0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(32'h10220010, mk(8'h05, 8'h03, 8'h10, 2'b01, 0, 6'h10, 5'd0, 0, 0, 0, 1), "beq", 0, w);
    chk("release_wait", 64'(w), 64'd0);

    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 8'h7A;
`ifdef ID_WB_BYPASS_EN
    issue(32'h00221820, mk(8'h7A, 8'h03, 8'h20, 2'b10, 0, 6'h20, 5'd3, 1, 0, 0, 0), "bypass_add", 0, w);
`else
    issue(32'h00221820, mk(8'h05, 8'h03, 8'h20, 2'b10, 0, 6'h20, 5'd3, 1, 0, 0, 0), "bypass_add", 0, w);
`endif
    wb_en = 1'b0;
    wb_write(5'd0, 8'h55);
    issue(32'h00013820, mk(8'h00, 8'h7A, 8'h20, 2'b10, 0, 6'h20, 5'd7, 1, 0, 0, 0), "r0_read", 0, w);

    issue(32'hFC221234, NOP_B, "illegal_nop", 0, w);
    chk("illegal_set", 64'(illegal), 64'd1);
    issue(32'h2024FFFE, mk(8'h7A, 8'h00, 8'hFE, 2'b00, 1, 6'h3E, 5'd4, 1, 0, 0, 0), "addi_after_ill", 0, w);
    chk("illegal_sticky", 64'(illegal), 64'd1);

    // Flush while the stall NOP is presented.
    issue(32'h8C250004, mk(8'h7A, 8'h00, 8'h04, 2'b00, 1, 6'h04, 5'd5, 1, 1, 0, 0), "lw_flush", 0, w);
    in_instr = 32'h00454020; in_valid = 1'b1;
    @(negedge clk);
    chk("hazard_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("stall_nop_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    issue(32'h00454020, mk(8'h03, 8'h00, 8'h20, 2'b10, 0, 6'h20, 5'd8, 1, 0, 0, 0), "add_after_flush", 0, w);
    chk("after_flush_wait", 64'(w), 64'd0);

    // Reset while stalled.
    issue(32'h8C250004, mk(8'h7A, 8'h00, 8'h04, 2'b00, 1, 6'h04, 5'd5, 1, 1, 0, 0), "lw_rst", 0, w);
    in_instr = 32'h00A23020; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_stall_out_valid", 64'(out_valid), 64'd0);
    chk("rst_clears_illegal", 64'(illegal), 64'd0);
    chk("rst_stall_in_ready", 64'(in_ready), 64'd1);
    issue(32'h00221820, mk(8'h00, 8'h00, 8'h20, 2'b10, 0, 6'h20, 5'd3, 1, 0, 0, 0), "add_after_rst", 0, w);
    chk("after_rst_wait", 64'(w), 64'd0);

    idle(3);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
